// File: rtl/sreg_stream_ctrl_if.sv
// Handshake bundle between a bit-stream FIFO controller and its neighbours.
// Carries the upstream valid/ready input, downstream valid/ready output, flush
// control/status, fill level and the three wires to the external SRL.
//   slave  : controller view (drives ready/valid/status and SRL ce/si)
//   master : environment view (drives data in, out_ready, flush_req, SRL so)
interface sreg_stream_ctrl_if #(
  parameter int unsigned CNT_W = 10
);
  logic             in_valid;
  logic             in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_data;
  logic             out_ready;
  logic             flush_req;
  logic             flush_busy;
  logic             flush_done;
  logic [CNT_W-1:0] fill_level;
  logic             sreg_ce;
  logic             sreg_si;
  logic             sreg_so;

  modport slave (
    input  in_valid, in_data, out_ready, flush_req, sreg_so,
    output in_ready, out_valid, out_data, flush_busy, flush_done, fill_level,
           sreg_ce, sreg_si
  );

  modport master (
    output in_valid, in_data, out_ready, flush_req, sreg_so,
    input  in_ready, out_valid, out_data, flush_busy, flush_done, fill_level,
           sreg_ce, sreg_si
  );
endinterface

// File: rtl/sreg_stream_ctrl.sv
// Sequencing controller that turns an external, non-resettable DEPTH-stage
// single-bit SRL into a fixed-latency bit FIFO with valid/ready on both sides.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset; starts a zero-flush when released
//   bus : sreg_stream_ctrl_if.slave (stream handshakes, flush, fill, SRL pins)
module sreg_stream_ctrl #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input logic               clk,
  input logic               rst,
  sreg_stream_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] FullLvl = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DEPTH - 1);

  typedef enum logic [0:0] {StFlush, StActive} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             out_valid_q, out_valid_d;
  logic             out_data_q, out_data_d;
  logic             accept;
  logic             evict;

  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    fill_d         = fill_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    accept         = 1'b0;
    evict          = 1'b0;
    bus.in_ready   = 1'b0;
    bus.sreg_ce    = 1'b0;
    bus.sreg_si    = 1'b0;
    bus.flush_done = 1'b0;

    // Under reset the SRL must not shift and nothing is accepted.
    if (!rst) begin
      unique case (state_q)
        StFlush: begin
          // Shift zeros through every stage; flush_req is ignored here.
          bus.sreg_ce = 1'b1;
          fill_d      = '0;
          out_valid_d = 1'b0;
          if (flush_cnt_q == LastCnt) begin
            bus.flush_done = 1'b1;
            flush_cnt_d    = '0;
            state_d        = StActive;
          end else begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
          end
        end
        StActive: begin
          if (bus.flush_req) begin
            // Flush beats a simultaneous input and discards any pending bit.
            state_d     = StFlush;
            flush_cnt_d = '0;
            fill_d      = '0;
            out_valid_d = 1'b0;
          end else begin
            // Only a full line with an unconsumed output bit stalls input.
            bus.in_ready = (fill_q < FullLvl) || !out_valid_q || bus.out_ready;
            accept       = bus.in_valid && bus.in_ready;
            bus.sreg_ce  = accept;
            bus.sreg_si  = bus.in_data;
            if (accept) begin
              if (fill_q < FullLvl) begin
                fill_d = fill_q + CNT_W'(1);
              end else begin
                // so is sampled at the same edge the SRL shifts it out.
                evict      = 1'b1;
                out_data_d = bus.sreg_so;
              end
            end
            if (evict) begin
              out_valid_d = 1'b1;
            end else if (bus.out_ready) begin
              out_valid_d = 1'b0;
            end
          end
        end
        default: state_d = StFlush;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFlush;
      flush_cnt_q <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.flush_busy = (state_q == StFlush);
  assign bus.fill_level = fill_q;

endmodule

// File: tb/tb_sreg_stream_ctrl.sv
// Bench for sreg_stream_ctrl with DEPTH=8: a behavioural SRL is attached to
// the sreg_* pins and every cycle is compared against a queue-based model of
// the bit FIFO (line contents, pending output bit, flush progress).
module tb_sreg_stream_ctrl;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 4;

  logic clk;
  logic rst;
  logic [DEPTH-1:0] srl;

  sreg_stream_ctrl_if #(.CNT_W(CNT_W)) sif ();

  sreg_stream_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External SRL: no reset, starts with junk so the flush has work to do.
  initial srl = 8'b1011_0111;
  always @(posedge clk) if (sif.sreg_ce) srl <= {srl[DEPTH-2:0], sif.sreg_si};
  assign sif.sreg_so = srl[DEPTH-1];

  int n_checks = 0;
  int n_err    = 0;

  // Reference model
  bit m_flushing = 1'b1;
  int m_fcnt     = 0;
  bit line[$];
  bit m_ov       = 1'b0;
  bit m_od       = 1'b0;
  int n_acc      = 0;
  int busy_seen  = 0;
  int out_seen   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check DUT outputs at negedge, advance the model at posedge.
  task automatic cycle(input string tag);
    bit exp_rdy;
    bit acc;
    bit ev;
    exp_rdy = 1'b0;
    @(negedge clk);
    if (!rst && sif.flush_busy === 1'b1) busy_seen++;
    if (!rst && sif.out_valid === 1'b1) out_seen++;
    if (rst) begin
      chk({tag, ".rst_ce"}, 32'(sif.sreg_ce), 0);
      chk({tag, ".rst_rdy"}, 32'(sif.in_ready), 0);
      chk({tag, ".rst_done"}, 32'(sif.flush_done), 0);
    end else if (m_flushing) begin
      chk({tag, ".fl_busy"}, 32'(sif.flush_busy), 1);
      chk({tag, ".fl_ce"}, 32'(sif.sreg_ce), 1);
      chk({tag, ".fl_si"}, 32'(sif.sreg_si), 0);
      chk({tag, ".fl_rdy"}, 32'(sif.in_ready), 0);
      chk({tag, ".fl_done"}, 32'(sif.flush_done), 32'(m_fcnt == DEPTH - 1));
      chk({tag, ".fl_fill"}, 32'(sif.fill_level), 0);
      chk({tag, ".fl_ov"}, 32'(sif.out_valid), 0);
    end else begin
      exp_rdy = !sif.flush_req && (line.size() < DEPTH || !m_ov || sif.out_ready);
      chk({tag, ".busy"}, 32'(sif.flush_busy), 0);
      chk({tag, ".done"}, 32'(sif.flush_done), 0);
      chk({tag, ".rdy"}, 32'(sif.in_ready), 32'(exp_rdy));
      chk({tag, ".ce"}, 32'(sif.sreg_ce), 32'(sif.in_valid && exp_rdy));
      if (sif.in_valid && exp_rdy) chk({tag, ".si"}, 32'(sif.sreg_si), 32'(sif.in_data));
      chk({tag, ".fill"}, 32'(sif.fill_level), line.size());
      chk({tag, ".ov"}, 32'(sif.out_valid), 32'(m_ov));
      if (m_ov) chk({tag, ".od"}, 32'(sif.out_data), 32'(m_od));
    end
    @(posedge clk);
    if (rst) begin
      m_flushing = 1'b1;
      m_fcnt     = 0;
      line.delete();
      m_ov       = 1'b0;
      m_od       = 1'b0;
    end else if (m_flushing) begin
      if (m_fcnt == DEPTH - 1) begin
        m_flushing = 1'b0;
        m_fcnt     = 0;
      end else begin
        m_fcnt++;
      end
    end else if (sif.flush_req) begin
      m_flushing = 1'b1;
      m_fcnt     = 0;
      line.delete();
      m_ov       = 1'b0;
    end else begin
      acc = sif.in_valid && exp_rdy;
      ev  = 1'b0;
      if (acc) begin
        n_acc++;
        line.push_back(sif.in_data);
        if (line.size() > DEPTH) begin
          m_od = line.pop_front();
          ev   = 1'b1;
        end
      end
      if (ev) m_ov = 1'b1;
      else if (sif.out_ready) m_ov = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input string tag, input int n);
    sif.in_valid  = 1'b0;
    sif.flush_req = 1'b0;
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic push(input string tag, input bit b);
    sif.in_valid = 1'b1;
    sif.in_data  = b;
    cycle(tag);
    sif.in_valid = 1'b0;
  endtask

  task automatic flush_cmd(input string tag);
    sif.flush_req = 1'b1;
    cycle(tag);
    sif.flush_req = 1'b0;
  endtask

  initial begin
    bit pat[10];
    int guard;
    pat = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1};
    rst           = 1'b1;
    sif.in_valid  = 1'b0;
    sif.in_data   = 1'b0;
    sif.out_ready = 1'b1;
    sif.flush_req = 1'b0;

    // 1: reset, then exactly DEPTH flush cycles before input is accepted.
    cycle("t1");
    cycle("t1");
    rst = 1'b0;
    chk("t1.od_reset", 32'(sif.out_data), 0);
    busy_seen = 0;
    idle("t1", 12);
    chk("t1.busy_cycles", busy_seen, DEPTH);
    chk("t1.srl_zero", 32'(srl), 0);

    // 2: fill and stream with out_ready held high.
    sif.out_ready = 1'b1;
    out_seen = 0;
    for (int i = 0; i < 10; i++) push("t2", pat[i]);
    idle("t2", 2);
    chk("t2.out_count", out_seen, 2);
    chk("t2.fill", 32'(sif.fill_level), DEPTH);

    // 3: backpressure on a full line, then random traffic over 200 bits.
    sif.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push("t3s", 1'($urandom_range(0, 1)));
    n_acc = 0;
    guard = 0;
    while (n_acc < 200 && guard < 5000) begin
      sif.in_valid  = ($urandom_range(0, 3) != 0);
      sif.in_data   = 1'($urandom_range(0, 1));
      sif.out_ready = ($urandom_range(0, 2) != 0);
      cycle("t3");
      guard++;
    end
    chk("t3.accepted", (n_acc >= 200), 1);
    sif.out_ready = 1'b1;
    idle("t3d", 2);

    // 4: flush wins over a simultaneous input at fill_level=5.
    flush_cmd("t4");
    idle("t4", DEPTH);
    for (int i = 0; i < 5; i++) push("t4", 1'($urandom_range(0, 1)));
    chk("t4.fill5", 32'(sif.fill_level), 5);
    sif.in_valid  = 1'b1;
    sif.in_data   = 1'b1;
    sif.flush_req = 1'b1;
    cycle("t4x");
    sif.flush_req = 1'b0;
    busy_seen = 0;
    idle("t4f", DEPTH + 1);
    chk("t4.busy_cycles", busy_seen, DEPTH);
    out_seen = 0;
    for (int i = 0; i < DEPTH; i++) push("t4p", 1'($urandom_range(0, 1)));
    idle("t4p", 1);
    chk("t4.no_output", out_seen, 0);

    // 5: pending output discarded by flush; repeated flush_req is ignored.
    sif.out_ready = 1'b0;
    push("t5", 1'b1);
    chk("t5.ov_set", 32'(sif.out_valid), 1);
    sif.out_ready = 1'b1;
    sif.flush_req = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 6; i++) cycle("t5f");
    sif.flush_req = 1'b0;
    idle("t5f", 6);
    chk("t5.busy_cycles", busy_seen, DEPTH);

    // 6: reset mid-flush and mid-stream restarts a full flush each time.
    flush_cmd("t6");
    idle("t6", 3);
    rst = 1'b1;
    cycle("t6r");
    rst = 1'b0;
    busy_seen = 0;
    idle("t6a", 12);
    chk("t6.busy_after_flush_rst", busy_seen, DEPTH);
    for (int i = 0; i < DEPTH; i++) push("t6", 1'($urandom_range(0, 1)));
    chk("t6.full", 32'(sif.fill_level), DEPTH);
    rst = 1'b1;
    cycle("t6r");
    rst = 1'b0;
    busy_seen = 0;
    idle("t6b", 12);
    chk("t6.busy_after_stream_rst", busy_seen, DEPTH);
    chk("t6.fill0", 32'(sif.fill_level), 0);
    chk("t6.ov0", 32'(sif.out_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/sreg_stream_ctrl.md
Name: sreg_stream_ctrl

Overview:
- Sequencing controller for an external single-bit, DEPTH-stage SRL shift register that has ports clk, ce, si and so, and no reset.
- Turns the raw shift register into a flow-controlled fixed-latency bit FIFO:
  - valid/ready on the input side;
  - valid/ready on the output side.
- Tracks fill level and emits the bits that fall off the end once the line is full.
- Performs zero-flush sequences after reset and on request, because the SRL itself cannot be reset.

Parameters:
- DEPTH, 512, stage count of the controlled shift register; must be ≥2.
- CNT_W, $clog2(DEPTH+1), width of the fill and flush counters.

Ports:
- clk, input, 1, single clock for all logic.
- rst, input, 1, synchronous reset, active-high.
- in_valid, input, 1, upstream offers in_data.
- in_data, input, 1, bit to shift into the line.
- in_ready, output, 1, controller accepts the bit this cycle.
- out_valid, output, 1, out_data holds a bit evicted from the line.
- out_data, output, 1, evicted bit.
- out_ready, input, 1, downstream consumes out_data.
- flush_req, input, 1, request to zero the line and discard its contents.
- flush_busy, output, 1, flush sequence in progress.
- flush_done, output, 1, single-cycle pulse on the last flush cycle.
- fill_level, output, CNT_W, number of valid bits held in the line (0..DEPTH).
- sreg_ce, output, 1, drives shift register ce.
- sreg_si, output, 1, drives shift register si.
- sreg_so, input, 1, shift register so (stage DEPTH-1, registered inside the SRL).

Behaviour:
- States: FLUSH, ACTIVE. No separate idle state; an empty line is ACTIVE with fill_level=0.
- Reset (rst=1 at a clock edge):
  - state=FLUSH, flush_cnt=0, fill_level=0, out_valid=0, out_data=0, flush_done=0.
  - While rst=1: sreg_ce=0, in_ready=0.
  - First cycle after rst deasserts starts a flush, since the SRL contents are unknown.
- FLUSH:
  - sreg_ce=1, sreg_si=0, in_ready=0, flush_busy=1.
  - flush_cnt increments each cycle.
  - The cycle with flush_cnt==DEPTH-1 asserts flush_done=1 (combinational on the state, 1 cycle) and moves to ACTIVE next cycle.
  - Total flush = exactly DEPTH cycles of ce.
  - fill_level held at 0. flush_req ignored; the flush does not restart.
- ACTIVE, entry into flush:
  - flush_req=1 forces in_ready=0 that cycle (flush wins over a simultaneous in_valid).
  - Next state FLUSH; flush_cnt cleared; fill_level cleared.
  - out_valid cleared at entry; a pending output bit is discarded even if out_ready=1 that cycle.
- ACTIVE, input acceptance:
  - in_ready = !flush_req && (fill_level<DEPTH || !out_valid || out_ready).
  - accept = in_valid && in_ready. sreg_ce=accept, sreg_si=in_data.
  - sreg_ce is combinational; no extra latency into the line.
- Fill and eviction:
  - If fill_level<DEPTH, accept increments fill_level and produces no output.
  - If fill_level==DEPTH, accept registers sreg_so into out_data and sets out_valid=1 next cycle. The evicted bit is the one sampled at the same edge the SRL shifts. fill_level stays at DEPTH.
- Output handshake:
  - out_valid clears when out_ready=1 and there is no new eviction that cycle.
  - Eviction and consumption in the same cycle leave out_valid=1 with the new bit.
  - out_data is stable while out_valid=1 and out_ready=0.
- Latency: the bit accepted as the k-th input (k≥1) appears on out_data one cycle after input number k+DEPTH is accepted. Throughput is 1 bit/cycle when out_ready=1.
- Stall: fill_level==DEPTH, out_valid=1, out_ready=0 → in_ready=0, sreg_ce=0, SRL contents frozen.
- flush_busy = (state==FLUSH). fill_level never exceeds DEPTH and never wraps.

Test Plan:
1. Reset then idle, DEPTH=8: rst high 2 cycles → flush_busy=1 for exactly 8 cycles with sreg_ce=1 and sreg_si=0; flush_done pulses on the 8th; in_ready=1 on the 9th cycle; fill_level=0.
2. Fill and stream, DEPTH=8, out_ready=1: push pattern 1,0,1,1,0,0,1,0,1,1 continuously → fill_level counts to 8; out_valid first rises one cycle after the 9th accept with out_data=1, then 0 after the 10th; fill_level stays 8.
3. Backpressure: full line, out_ready=0, in_valid=1 → one eviction, then in_ready=0 and sreg_ce=0 until out_ready=1; no bit lost or duplicated, checked against a reference queue over 200 random bits.
4. Flush mid-stream: fill_level=5, flush_req and in_valid both 1 in the same cycle → input not accepted; 8 flush cycles with out_valid=0; fill_level=0; the next 8 accepted bits produce no output.
5. Pending output discarded: out_valid=1, out_ready=1, flush_req=1 in the same cycle → out_valid=0 next cycle; flush_req repeated during FLUSH does not lengthen the 8-cycle sequence.
6. Reset mid-flush and mid-stream: assert rst at flush_cnt=3 and again at fill_level=8 → a full 8-cycle flush restarts each time; fill_level=0, out_valid=0.
